ofm_drain: RTL and testbench

OFM_DRAIN -- requirements
Module: ofm_drain

---
 rtl/ofm_drain.sv | 176 +++++++++++++++++
 tb/tb_ofm_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain.sv
// Output-feature-map drain: captures a completed MAC tile, adds per-channel bias,
// applies optional ReLU and streams elements out in x, y, f order over valid/ready.
module ofm_drain #(
  parameter int POF = 4,
  parameter int POX = 7,
  parameter int POY = 7,
  parameter int DW  = 32,
  localparam int FW = (POF > 1) ? $clog2(POF) : 1,
  localparam int XW = (POX > 1) ? $clog2(POX) : 1,
  localparam int YW = (POY > 1) ? $clog2(POY) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tile_valid,
  output logic                        tile_ready,
  input  logic [POF*POX*POY*DW-1:0]   tile_in,
  input  logic [POF*DW-1:0]           bias_in,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_data,
  output logic [FW-1:0]               out_f,
  output logic [XW-1:0]               out_x,
  output logic [YW-1:0]               out_y,
  output logic                        out_last,
  output logic [15:0]                 tile_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                      state_r, state_s;
  logic [POF*POX*POY*DW-1:0]   tile_r;
  logic [POF*DW-1:0]           bias_r;
  logic                        relu_r;
  logic [FW-1:0]               f_r, f_s;
  logic [XW-1:0]               x_r, x_s;
  logic [YW-1:0]               y_r, y_s;
  logic [DW-1:0]               data_r, data_s;
  logic                        last_r, last_s;
  logic [15:0]                 cnt_r, cnt_s;
  logic                        capture_s;

  // Bias add with DW-bit wraparound, then optional clamp of negative sums to zero.
  function automatic logic [DW-1:0] elem_proc(
    input logic [POF*POX*POY*DW-1:0] t,
    input logic [POF*DW-1:0]         b,
    input logic                      r,
    input logic [FW-1:0]             f,
    input logic [XW-1:0]             x,
    input logic [YW-1:0]             y
  );
    int            idx;
    logic [DW-1:0] sum;
    idx = ((int'(f) * POY + int'(y)) * POX + int'(x)) * DW;
    sum = t[idx +: DW] + b[int'(f) * DW +: DW];
    if (r && sum[DW-1]) begin
      return {DW{1'b0}};
    end else begin
      return sum;
    end
  endfunction

  function automatic logic is_last(
    input logic [FW-1:0] f,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    return (f == FW'(POF - 1)) && (x == XW'(POX - 1)) && (y == YW'(POY - 1));
  endfunction

  assign capture_s = (state_r == IDLE) && tile_valid;

  // Next-state, index walk and pre-computed next output element.
  always_comb begin
    state_s = state_r;
    f_s     = f_r;
    x_s     = x_r;
    y_s     = y_r;
    data_s  = data_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (tile_valid) begin
          state_s = DRAIN;
          f_s     = {FW{1'b0}};
          x_s     = {XW{1'b0}};
          y_s     = {YW{1'b0}};
          data_s  = elem_proc(tile_in, bias_in, relu_en, {FW{1'b0}}, {XW{1'b0}}, {YW{1'b0}});
          last_s  = is_last({FW{1'b0}}, {XW{1'b0}}, {YW{1'b0}});
        end else begin
          last_s  = 1'b0;
        end
      end
      DRAIN: begin
        if (out_ready && last_r) begin
          state_s = IDLE;
          last_s  = 1'b0;
          cnt_s   = cnt_r + 16'd1;
        end else if (out_ready) begin
          // x runs fastest, then y, with f as the outermost loop.
          if (x_r == XW'(POX - 1)) begin
            x_s = {XW{1'b0}};
            if (y_r == YW'(POY - 1)) begin
              y_s = {YW{1'b0}};
              f_s = f_r + FW'(1);
            end else begin
              y_s = y_r + YW'(1);
            end
          end else begin
            x_s = x_r + XW'(1);
          end
          data_s = elem_proc(tile_r, bias_r, relu_r, f_s, x_s, y_s);
          last_s = is_last(f_s, x_s, y_s);
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        last_s  = 1'b0;
      end
    endcase
  end

  // State, indices and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      f_r     <= {FW{1'b0}};
      x_r     <= {XW{1'b0}};
      y_r     <= {YW{1'b0}};
      data_r  <= {DW{1'b0}};
      last_r  <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      f_r     <= f_s;
      x_r     <= x_s;
      y_r     <= y_s;
      data_r  <= data_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
    end
  end

  // Tile snapshot; only the handshake cycle loads it, so later input changes are invisible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_r <= {(POF*POX*POY*DW){1'b0}};
      bias_r <= {(POF*DW){1'b0}};
      relu_r <= 1'b0;
    end else if (capture_s) begin
      tile_r <= tile_in;
      bias_r <= bias_in;
      relu_r <= relu_en;
    end else begin
      tile_r <= tile_r;
      bias_r <= bias_r;
      relu_r <= relu_r;
    end
  end

  assign tile_ready = (state_r == IDLE);
  assign out_valid  = (state_r == DRAIN);
  assign out_data   = data_r;
  assign out_f      = f_r;
  assign out_x      = x_r;
  assign out_y      = y_r;
  assign out_last   = last_r;
  assign tile_cnt   = cnt_r;

endmodule

// File: tb/tb_ofm_drain.sv
// Directed self-checking bench for ofm_drain with default 4x7x7x32 tiles.
module tb_ofm_drain;
  localparam int POF = 4;
  localparam int POX = 7;
  localparam int POY = 7;
  localparam int DW  = 32;
  localparam int NE  = POF * POX * POY;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      tile_valid;
  logic                      tile_ready;
  logic [POF*POX*POY*DW-1:0] tile_in;
  logic [POF*DW-1:0]         bias_in;
  logic                      relu_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW-1:0]             out_data;
  logic [1:0]                out_f;
  logic [2:0]                out_x;
  logic [2:0]                out_y;
  logic                      out_last;
  logic [15:0]               tile_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_d [0:NE-1];
  int          got_f [0:NE-1];
  int          got_x [0:NE-1];
  int          got_y [0:NE-1];
  logic        got_l [0:NE-1];
  int          n_xfer;
  int          cycles_used;
  int          stall_viol;

  ofm_drain #(.POF(POF), .POX(POX), .POY(POY), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_in(tile_in), .bias_in(bias_in), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_f(out_f), .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  // kind 0: f*100+y*10+x; 1: -5 with bias f*3 and relu; 2: 0x7FFFFFFF bias 1; 3: constant 7; 4: junk
  function automatic logic [31:0] exp_val(input int kind, input int i);
    int f, x, y, s;
    f = i / (POX * POY);
    y = (i / POX) % POY;
    x = i % POX;
    case (kind)
      0: return 32'(f * 100 + y * 10 + x);
      1: begin
        s = -5 + f * 3;
        return (s < 0) ? 32'd0 : 32'(s);
      end
      2: return 32'h8000_0000;
      3: return 32'd7;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic set_tile(input int kind);
    logic [31:0] v;
    for (int f = 0; f < POF; f++) begin
      for (int y = 0; y < POY; y++) begin
        for (int x = 0; x < POX; x++) begin
          case (kind)
            0: v = 32'(f * 100 + y * 10 + x);
            1: v = -32'sd5;
            2: v = 32'h7FFF_FFFF;
            3: v = 32'd7;
            default: v = 32'hDEAD_0000 + 32'(x + y * 16 + f * 256);
          endcase
          tile_in[((f * POY + y) * POX + x) * DW +: DW] = v;
        end
      end
      bias_in[f * DW +: DW] = (kind == 1) ? 32'(f * 3) : (kind == 2) ? 32'd1 :
                              (kind == 4) ? 32'd5 : 32'd0;
    end
    relu_en = (kind == 1) || (kind == 4);
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the capture edge.
  task automatic send_tile(input int kind);
    set_tile(kind);
    tile_valid = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
  endtask

  // Collects transfers; mode 0 keeps out_ready high, mode 1 repeats 1,0,0,1.
  task automatic run_drain(input int mode, input int stop_after);
    int          cyc;
    logic        prev_stall;
    logic        seen_last;
    logic [40:0] prev_out;
    cyc = 0; prev_stall = 1'b0; seen_last = 1'b0; prev_out = 41'd0;
    n_xfer = 0; stall_viol = 0;
    while (n_xfer < stop_after && !seen_last && cyc < 4000) begin
      if (prev_stall && ({out_data, out_f, out_x, out_y, out_last} !== prev_out))
        stall_viol++;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (out_valid && out_ready) begin
        got_d[n_xfer] = out_data;
        got_f[n_xfer] = int'(out_f);
        got_x[n_xfer] = int'(out_x);
        got_y[n_xfer] = int'(out_y);
        got_l[n_xfer] = out_last;
        seen_last = out_last;
        n_xfer++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_data, out_f, out_x, out_y, out_last};
      cyc++;
      @(negedge clk);
    end
    cycles_used = cyc;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tile_valid = 1'b0; out_ready = 1'b0;
    set_tile(0);
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_last, tile_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got v/l/r=%b%b%b want 001", out_valid, out_last, tile_ready);
    end
    checks++;
    if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++;
    if (tile_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", tile_cnt); end
    checks++;
    if ({out_f, out_x, out_y} !== 8'd0) begin
      errors++; $display("FAIL reset_idx: got f%0d x%0d y%0d want 0", out_f, out_x, out_y);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_stream(input string name, input int kind, input int n_exp);
    checks++;
    if (n_xfer !== n_exp) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, n_xfer, n_exp); end
    for (int i = 0; i < n_xfer && i < n_exp; i++) begin
      checks++;
      if (got_d[i] !== exp_val(kind, i) || got_f[i] != i / (POX * POY) ||
          got_y[i] != (i / POX) % POY || got_x[i] != i % POX || got_l[i] !== (i == NE - 1)) begin
        errors++;
        $display("FAIL %s_elem%0d: got d=%h f%0d x%0d y%0d l%b want d=%h f%0d x%0d y%0d l%b",
                 name, i, got_d[i], got_f[i], got_x[i], got_y[i], got_l[i], exp_val(kind, i),
                 i / (POX * POY), i % POX, (i / POX) % POY, i == NE - 1);
      end
    end
  endtask

  task automatic test_basic;
    send_tile(0);
    checks++;
    if ({out_valid, tile_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_latency: got v/r=%b%b want 10", out_valid, tile_ready);
    end
    run_drain(0, NE);
    check_stream("basic", 0, NE);
    checks++;
    if (cycles_used !== NE) begin errors++; $display("FAIL basic_cycles: got %0d want %0d", cycles_used, NE); end
    checks++;
    if ({tile_ready, out_valid, out_last} !== 3'b100) begin
      errors++; $display("FAIL basic_idle: got r/v/l=%b%b%b want 100", tile_ready, out_valid, out_last);
    end
    checks++;
    if (tile_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", tile_cnt); end
  endtask

  task automatic test_relu;
    send_tile(1);
    run_drain(0, NE);
    check_stream("relu", 1, NE);
    checks++;
    if (tile_cnt !== 16'd2) begin errors++; $display("FAIL relu_cnt: got %0d want 2", tile_cnt); end
  endtask

  task automatic test_wrap;
    send_tile(2);
    checks++;
    if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL wrap_first: got %h want 80000000", out_data); end
    run_drain(0, NE);
    check_stream("wrap", 2, NE);
    checks++;
    if (tile_cnt !== 16'd3) begin errors++; $display("FAIL wrap_cnt: got %0d want 3", tile_cnt); end
  endtask

  task automatic test_stall;
    send_tile(0);
    set_tile(4);
    run_drain(1, NE);
    check_stream("stall", 0, NE);
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
    checks++;
    if (tile_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", tile_cnt); end
  endtask

  task automatic test_back_to_back;
    set_tile(0);
    tile_valid = 1'b1;
    @(negedge clk);
    set_tile(3);
    run_drain(0, NE);
    check_stream("b2b_first", 0, NE);
    checks++;
    if ({tile_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_idle: got r/v=%b%b want 10", tile_ready, out_valid);
    end
    @(negedge clk);
    tile_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd7) begin
      errors++; $display("FAIL b2b_capture: got v=%b d=%h want v=1 d=7", out_valid, out_data);
    end
    run_drain(0, NE);
    check_stream("b2b_second", 3, NE);
    checks++;
    if (tile_cnt !== 16'd6) begin errors++; $display("FAIL b2b_cnt: got %0d want 6", tile_cnt); end
  endtask

  task automatic test_reset_mid;
    send_tile(0);
    run_drain(0, 50);
    checks++;
    if (n_xfer !== 50) begin errors++; $display("FAIL rmid_partial: got %0d want 50", n_xfer); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last} !== 2'b00 || tile_cnt !== 16'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL rmid_reset: got v=%b l=%b cnt=%0d d=%h want 0 0 0 0", out_valid, out_last, tile_cnt, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({tile_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL rmid_ready: got r/v=%b%b want 10", tile_ready, out_valid);
    end
    send_tile(0);
    run_drain(0, NE);
    check_stream("rmid_next", 0, NE);
    checks++;
    if (tile_cnt !== 16'd1) begin errors++; $display("FAIL rmid_cnt: got %0d want 1", tile_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
